// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter that serialises read/write commands onto a
// single-port memory with a registered read; one command in flight at a time.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid_0,
  input  logic                  req_valid_1,
  output logic                  req_ready_0,
  output logic                  req_ready_1,
  input  logic                  req_we_0,
  input  logic                  req_we_1,
  input  logic [ADDR_WIDTH-1:0] req_addr_0,
  input  logic [ADDR_WIDTH-1:0] req_addr_1,
  input  logic [DATA_WIDTH-1:0] req_wdata_0,
  input  logic [DATA_WIDTH-1:0] req_wdata_1,
  output logic                  resp_valid_0,
  output logic                  resp_valid_1,
  output logic [DATA_WIDTH-1:0] resp_rdata_0,
  output logic [DATA_WIDTH-1:0] resp_rdata_1,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd_en,
  output logic                  mem_wr_en,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t                state_q;
  logic                  prio_q;
  logic                  owner_q;
  logic                  we_q;
  logic                  mem_rd_en_q;
  logic                  mem_wr_en_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;
  logic [1:0]            resp_valid_q;
  logic [DATA_WIDTH-1:0] resp_rdata_q [2];

  logic                  grant_0;
  logic                  grant_1;
  logic                  owner_d;
  logic                  we_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0] wdata_d;

  // Ready is withheld while reset is asserted so it first rises after release.
  assign grant_0 = !reset && (state_q == IDLE) && req_valid_0 && (!req_valid_1 || !prio_q);
  assign grant_1 = !reset && (state_q == IDLE) && req_valid_1 && (!req_valid_0 ||  prio_q);

  assign owner_d = grant_1;
  assign we_d    = grant_1 ? req_we_1    : req_we_0;
  assign addr_d  = grant_1 ? req_addr_1  : req_addr_0;
  assign wdata_d = grant_1 ? req_wdata_1 : req_wdata_0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      prio_q          <= 1'b0;
      owner_q         <= 1'b0;
      we_q            <= 1'b0;
      mem_rd_en_q     <= 1'b0;
      mem_wr_en_q     <= 1'b0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
      resp_valid_q    <= '0;
      resp_rdata_q[0] <= '0;
      resp_rdata_q[1] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_0 || grant_1) begin
            owner_q     <= owner_d;
            we_q        <= we_d;
            mem_addr_q  <= addr_d;
            mem_wdata_q <= wdata_d;
            mem_rd_en_q <= !we_d;
            mem_wr_en_q <= we_d;
            prio_q      <= !owner_d;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          mem_rd_en_q <= 1'b0;
          mem_wr_en_q <= 1'b0;
          state_q     <= CAPTURE;
        end
        CAPTURE: begin
          // Memory read data is valid only now, one cycle after the enable.
          resp_rdata_q[owner_q] <= we_q ? '0 : mem_rdata;
          resp_valid_q[owner_q] <= 1'b1;
          state_q               <= RESP;
        end
        RESP: begin
          resp_valid_q <= '0;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready_0  = grant_0;
  assign req_ready_1  = grant_1;
  assign resp_valid_0 = resp_valid_q[0];
  assign resp_valid_1 = resp_valid_q[1];
  assign resp_rdata_0 = resp_rdata_q[0];
  assign resp_rdata_1 = resp_rdata_q[1];
  assign mem_addr     = mem_addr_q;
  assign mem_rd_en    = mem_rd_en_q;
  assign mem_wr_en    = mem_wr_en_q;
  assign mem_wdata    = mem_wdata_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a registered-read memory fixture, a cycle-level
// transaction model checked every cycle, directed scenarios and random traffic.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  rv;
  logic [1:0]  rdy;
  logic [1:0]  rwe;
  logic [3:0]  raddr [2];
  logic [15:0] rwd   [2];
  logic        resp_v0, resp_v1;
  logic [15:0] resp_d0, resp_d1;
  logic [3:0]  mem_addr;
  logic        mem_rd_en, mem_wr_en;
  logic [15:0] mem_wdata, mem_rdata;
  logic        busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_WIDTH(4), .DATA_WIDTH(16)) dut (
    .clk(clk), .reset(reset),
    .req_valid_0(rv[0]), .req_valid_1(rv[1]),
    .req_ready_0(rdy[0]), .req_ready_1(rdy[1]),
    .req_we_0(rwe[0]), .req_we_1(rwe[1]),
    .req_addr_0(raddr[0]), .req_addr_1(raddr[1]),
    .req_wdata_0(rwd[0]), .req_wdata_1(rwd[1]),
    .resp_valid_0(resp_v0), .resp_valid_1(resp_v1),
    .resp_rdata_0(resp_d0), .resp_rdata_1(resp_d1),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  // Single-port memory with a one-cycle registered read, cleared by reset.
  logic [15:0] mem_arr [16];
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) mem_arr[i] <= '0;
      mem_rdata <= '0;
    end else begin
      if (mem_wr_en) mem_arr[mem_addr] <= mem_wdata;
      if (mem_rd_en) mem_rdata <= mem_arr[mem_addr];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: each accepted command occupies 4 cycles; enables in the cycle after
  // acceptance, response two cycles later. Expected read data comes from a
  // plain array updated in acceptance order.
  int          n = 0;
  int          issue_cyc = -10, resp_cyc = -10, free_at = 0;
  logic        m_prio = 1'b0, m_owner = 1'b0, m_we = 1'b0;
  logic [15:0] m_mem [16];
  logic [15:0] pend = '0;
  logic [15:0] exp_rd [2];
  logic [3:0]  last_addr = '0;
  logic [15:0] last_wd = '0;
  logic        idle, w0, w1;
  int          grants[$];
  int          rd_cnt = 0, rv1_cnt = 0;

  always @(negedge clk) begin
    if (reset) begin
      chk("rst_ready_0", rdy[0], 0);    chk("rst_ready_1", rdy[1], 0);
      chk("rst_busy", busy, 0);
      chk("rst_rd_en", mem_rd_en, 0);   chk("rst_wr_en", mem_wr_en, 0);
      chk("rst_mem_addr", mem_addr, 0); chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_resp_valid_0", resp_v0, 0); chk("rst_resp_valid_1", resp_v1, 0);
      chk("rst_resp_rdata_0", resp_d0, 0); chk("rst_resp_rdata_1", resp_d1, 0);
      for (int i = 0; i < 16; i++) m_mem[i] = '0;
      exp_rd[0] = '0; exp_rd[1] = '0;
      last_addr = '0; last_wd = '0; m_prio = 1'b0;
      issue_cyc = -10; resp_cyc = -10; free_at = 0;
    end else begin
      if (n == resp_cyc) exp_rd[m_owner] = pend;
      idle = (n >= free_at);
      w0 = idle && rv[0] && (!rv[1] || !m_prio);
      w1 = idle && rv[1] && (!rv[0] ||  m_prio);
      chk("req_ready_0", rdy[0], w0);
      chk("req_ready_1", rdy[1], w1);
      chk("busy", busy, !idle);
      chk("mem_rd_en", mem_rd_en, (n == issue_cyc) && !m_we);
      chk("mem_wr_en", mem_wr_en, (n == issue_cyc) && m_we);
      chk("mem_addr", mem_addr, last_addr);
      chk("mem_wdata", mem_wdata, last_wd);
      chk("resp_valid_0", resp_v0, (n == resp_cyc) && (m_owner == 1'b0));
      chk("resp_valid_1", resp_v1, (n == resp_cyc) && (m_owner == 1'b1));
      chk("resp_rdata_0", resp_d0, exp_rd[0]);
      chk("resp_rdata_1", resp_d1, exp_rd[1]);
      if (w0 || w1) begin
        m_owner   = w1;
        m_we      = rwe[w1];
        pend      = m_we ? 16'h0 : m_mem[raddr[w1]];
        if (m_we) m_mem[raddr[w1]] = rwd[w1];
        last_addr = raddr[w1];
        last_wd   = rwd[w1];
        m_prio    = !w1;
        issue_cyc = n + 1;
        resp_cyc  = n + 3;
        free_at   = n + 4;
        $display("txn port=%0d %s addr=%0h wdata=%h exp_rdata=%h", w1,
                 m_we ? "WR" : "RD", last_addr, last_wd, pend);
      end
    end
    if (rdy[0] && rv[0]) grants.push_back(0);
    if (rdy[1] && rv[1]) grants.push_back(1);
    if (mem_rd_en) rd_cnt++;
    if (resp_v1) rv1_cnt++;
    n++;
  end

  // Present a command on port k and wait (bounded) for its acceptance edge.
  task automatic drive(input int k, input logic we, input logic [3:0] a,
                       input logic [15:0] d, input bit keep);
    rv[k] = 1'b1; rwe[k] = we; raddr[k] = a; rwd[k] = d;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rdy[k]) break;
    end
    if (!rdy[k]) chk("ready_timeout", rdy[k], 1);
    @(posedge clk); #1;
    if (!keep) rv[k] = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    repeat (cycles) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic wait_cycles(input int c);
    repeat (c) @(posedge clk);
    #1;
  endtask

  int g0, rc0, vc0;
  logic a0, a1;

  initial begin
    reset = 1'b1; rv = '0; rwe = '0;
    raddr[0] = '0; raddr[1] = '0; rwd[0] = '0; rwd[1] = '0;

    // Reset held three cycles with port 0 requesting.
    rv[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("ready0_first_cycle_after_reset", rdy[0], 1);
    @(posedge clk); #1 rv[0] = 1'b0;
    wait_cycles(4);

    // Write then read on port 0.
    drive(0, 1'b1, 4'd5, 16'hBEEF, 0);
    wait_cycles(3);
    chk("write_completion_rdata", resp_d0, 16'h0000);
    drive(0, 1'b0, 4'd5, 16'h0000, 0);
    wait_cycles(3);
    chk("read_after_write_5", resp_d0, 16'hBEEF);

    // Contention straight after reset.
    do_reset(2);
    g0 = grants.size();
    fork
      begin drive(0, 1'b0, 4'd2, 16'h0, 1); drive(0, 1'b0, 4'd2, 16'h0, 0); end
      begin drive(1, 1'b1, 4'd2, 16'h1234, 1); drive(1, 1'b0, 4'd2, 16'h0, 0); end
    join
    wait_cycles(4);
    chk("contention_grant_count", grants.size() - g0, 4);
    if (grants.size() - g0 == 4) begin
      chk("grant_order_a", grants[g0],     0);
      chk("grant_order_b", grants[g0 + 1], 1);
      chk("grant_order_c", grants[g0 + 2], 0);
      chk("grant_order_d", grants[g0 + 3], 1);
    end
    chk("contention_port0_read", resp_d0, 16'h1234);
    chk("contention_port1_read", resp_d1, 16'h1234);

    // Top address.
    drive(1, 1'b1, 4'd15, 16'hFFFF, 0);
    wait_cycles(3);
    drive(0, 1'b0, 4'd15, 16'h0, 0);
    wait_cycles(3);
    chk("addr15_read", resp_d0, 16'hFFFF);
    drive(0, 1'b0, 4'd0, 16'h0, 0);
    wait_cycles(3);
    chk("addr0_read", resp_d0, 16'h0000);

    // Reset during CAPTURE of a port-1 read.
    vc0 = rv1_cnt;
    drive(1, 1'b0, 4'd15, 16'h0, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("midrst_busy_immediate", busy, 0);
    chk("midrst_rd_en_immediate", mem_rd_en, 0);
    chk("midrst_resp1_immediate", resp_v1, 0);
    @(posedge clk); #1 reset = 1'b0;
    wait_cycles(4);
    chk("midrst_no_resp1", rv1_cnt - vc0, 0);
    g0 = grants.size();
    fork
      drive(0, 1'b0, 4'd1, 16'h0, 0);
      drive(1, 1'b0, 4'd1, 16'h0, 0);
    join
    chk("midrst_first_grant", grants[g0], 0);
    wait_cycles(4);

    // Port 0 valid held 4 extra cycles after ready.
    g0 = grants.size(); rc0 = rd_cnt;
    rv[0] = 1'b1; rwe[0] = 1'b0; raddr[0] = 4'd3;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rdy[0]) break;
    end
    repeat (5) @(posedge clk);
    #1 rv[0] = 1'b0;
    wait_cycles(6);
    chk("hold_extra_grants", grants.size() - g0, 2);
    chk("hold_rd_en_cycles", rd_cnt - rc0, 2);

    // Random traffic with occasional resets.
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      a0 = rdy[0] && rv[0];
      a1 = rdy[1] && rv[1];
      @(posedge clk); #1;
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 96) == 0) reset = 1'b1;
      for (int k = 0; k < 2; k++) begin
        if ((k == 0 ? a0 : a1) || !rv[k]) begin
          rv[k]    = ($urandom_range(0, 2) != 0);
          rwe[k]   = $urandom_range(0, 1) == 1;
          raddr[k] = ($urandom_range(0, 4) == 4) ? 4'd15 : 4'($urandom_range(0, 3));
          rwd[k]   = 16'($urandom);
        end else if ($urandom_range(0, 15) == 0) begin
          rv[k] = 1'b0;
        end
      end
    end
    rv = '0;
    reset = 1'b0;
    wait_cycles(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

- Two-requester, round-robin arbiter and sequencer for the single-port `memory` block; ADDR_WIDTH=4 and DATA_WIDTH=16 by default.
- Each requester issues one read or write at a time over a valid/ready handshake and gets back exactly one single-cycle response.
- The block drives the memory's `addr`, `rd_en`, `wr_en` and `wdata` from registers and captures its `rdata`.
- It sits between the memory and its two clients; the memory's `reset` is wired from the same reset net, not driven by this block.

## Interface
- ADDR_WIDTH, 4, memory address width
- DATA_WIDTH, 16, memory data width
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- req_valid_0 / req_valid_1  in  1  requester k has a command pending
- req_ready_0 / req_ready_1  out  1  command of requester k accepted this cycle
- req_we_0 / req_we_1  in  1  1 = write, 0 = read
- req_addr_0 / req_addr_1  in  ADDR_WIDTH  target address
- req_wdata_0 / req_wdata_1  in  DATA_WIDTH  write data (ignored for reads)
- resp_valid_0 / resp_valid_1  out  1  one-cycle completion pulse for requester k
- resp_rdata_0 / resp_rdata_1  out  DATA_WIDTH  read data; 0 for write completions
- mem_addr  out  ADDR_WIDTH  to memory `addr`
- mem_rd_en  out  1  to memory `rd_en`
- mem_wr_en  out  1  to memory `wr_en`
- mem_wdata  out  DATA_WIDTH  to memory `wdata`
- mem_rdata  in  DATA_WIDTH  from memory `rdata`
- busy  out  1  high in every state except IDLE

## Operation
**FSM states:** IDLE → ISSUE → CAPTURE → RESP → IDLE. No other transitions.

**IDLE**
- Arbitrate among the asserted `req_valid_k`.
- If only one is valid, it wins.
- If both are valid, the port named by `prio` wins.
- `req_ready_k` is combinational: (state==IDLE) && winner==k. At most one ready is high at a time.
- On the accepting edge:
  - register owner=k, we, addr and wdata into the mem_* registers;
  - set `prio` to the other port;
  - move to ISSUE.

**ISSUE**
- `mem_rd_en` = !we, `mem_wr_en` = we, high for exactly this cycle.
- The memory executes the operation at the closing edge.

**CAPTURE**
- Enables are low; `mem_rdata` now holds the read result.
- At the closing edge, register `resp_rdata_owner` = we ? 0 : `mem_rdata`.
- Assert `resp_valid_owner` for the next cycle.

**RESP**
- `resp_valid_owner` is high for exactly this cycle; there is no response backpressure.
- Return to IDLE.

**Requester rules**
- `req_*` must stay stable while valid and not ready.
- A requester may drop valid without penalty before it is accepted.

**Output holding**
- `mem_addr` and `mem_wdata` hold their last value outside ISSUE.
- `resp_rdata_k` holds until the next completion for port k.

## Timing
**Reset values (asserted asynchronously):**
- state=IDLE, prio=0, owner=0;
- mem_addr=0, mem_wdata=0, mem_rd_en=0, mem_wr_en=0;
- resp_valid_*=0, resp_rdata_*=0, busy=0;
- req_ready_* reflects IDLE arbitration as soon as reset deasserts.

**Latency and throughput:**
- Accept edge T0; mem enables high during [T0,T1]; `resp_valid` high during [T2,T3].
- Completion is therefore 3 cycles after acceptance for both reads and writes.
- Next accept is at T4 at the earliest, giving at most one transaction per 4 cycles.

**Fairness:** with both ports continuously valid, grants strictly alternate 0,1,0,1… starting at port 0 after reset. Worst-case wait is one transaction (4 cycles).

**Boundary conditions:**
- Read immediately after a write to the same address returns the new data, because the write completes in the memory before the read is issued.
- Addresses wrap naturally; 2^ADDR_WIDTH−1 is a legal address with no special case.
- A new `req_valid` arriving while busy is not accepted and no ready is raised. The request is arbitrated on the first IDLE cycle.
- Reset asserted in any state:
  - the in-flight transaction is dropped and no `resp_valid` is produced;
  - enables fall in the same cycle;
  - `prio` returns to 0.
- A write in flight when reset hits is not guaranteed to land; the memory is cleared by the same reset regardless.

## Test plan
- **Reset/idle:** hold reset 3 cycles with req_valid_0=1 → all outputs at their reset values and busy=0. req_ready_0 rises in the first cycle after deassert.
- **Single write-then-read:** port 0 writes 0xBEEF to addr 5, then reads addr 5 → resp_valid_0 pulses 3 cycles after each accept; read returns 0xBEEF; write completion returns rdata 0.
- **Contention:** both ports valid continuously right after reset; port 0 reads addr 2 and port 1 writes 0x1234 to addr 2 → grant order 0,1,0,1; port 0's second read returns 0x1234; each response appears only on its owner's port.
- **Boundary address:** port 1 writes 0xFFFF to addr 15, then port 0 reads addr 15 → port 0 gets 0xFFFF and addr 0 still reads 0.
- **Mid-operation reset:** assert reset during CAPTURE of a port-1 read → no resp_valid_1 pulse and enables low immediately; after release, with both ports valid, port 0 is granted first.
- **Stability/no-double-issue:** port 0 valid is held for 4 extra cycles after its ready → exactly one additional transaction is accepted, at the next IDLE; mem_rd_en is high for exactly one cycle per transaction.
